// File: rtl/enemy_formation.sv
// Enemy formation for a fixed-shooter game: a ROWS x COLS grid of sprites
// that marches sideways, drops at the field edges, takes shots and draws
// itself into the pixel stream.
//
// Optional feature (macro FORMATION_SPEEDUP_EN): the march period shrinks
// in proportion to the number of living enemies.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   tick                one-cycle frame pulse feeding the march divider
//   restart             synchronous reload of the formation
//   h_counter/v_counter pixel position being drawn
//   shot_valid/x/y      player shot point
//   hit, hit_id         one-cycle kill pulse and index of the killed enemy
//   alive_count         number of living enemies
//   cleared             every enemy is dead
//   reached_bottom      lowest living row touched Y_FLOOR
//   R, G, B             pixel colour, one cycle after h_counter/v_counter
module enemy_formation #(
    parameter int ROWS     = 3,
    parameter int COLS     = 8,
    parameter int X0       = 180,
    parameter int Y0       = 40,
    parameter int DX       = 80,
    parameter int DY       = 50,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 24,
    parameter int STEP     = 8,
    parameter int DROP     = 16,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_FLOOR  = 440,
    parameter int MOVE_DIV = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        restart,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        shot_valid,
    input  logic [10:0] shot_x,
    input  logic [10:0] shot_y,
    output logic        hit,
    output logic [4:0]  hit_id,
    output logic [5:0]  alive_count,
    output logic        cleared,
    output logic        reached_bottom,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    localparam int unsigned N    = int'(ROWS * COLS);
    localparam int unsigned CW   = 13;  // signed pixel coordinates; base_x may go negative
    localparam int unsigned IDW  = 5;
    localparam int unsigned CNTW = 6;
    localparam int unsigned DW   = $clog2(MOVE_DIV + 1);
    localparam logic [7:0]  ENEMY_R = 8'hFF;
    localparam logic [7:0]  ENEMY_G = 8'hFF;
    localparam logic [7:0]  ENEMY_B = 8'hFF;

    typedef enum logic [1:0] {
        MARCH_R = 2'd0,
        MARCH_L = 2'd1,
        DESCEND = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 from_left, from_left_nxt;
    logic signed [CW-1:0] base_x, base_x_nxt;
    logic signed [CW-1:0] base_y, base_y_nxt;
    logic [N-1:0]         alive, alive_nxt;
    logic [DW-1:0]        tick_cnt, tick_cnt_nxt;
    logic                 hit_nxt;
    logic [IDW-1:0]       hit_id_nxt;
    logic [CNTW-1:0]      alive_count_nxt;
    logic                 cleared_nxt;
    logic                 bottom_nxt;
    logic                 march_ev;

    logic [COLS-1:0]      col_alive;
    logic [ROWS-1:0]      row_alive;
    logic signed [CW-1:0] right_edge, left_edge, bottom_edge;
    logic                 floor_hit;
    logic                 shot_hit;
    logic [IDW-1:0]       shot_idx;
    logic signed [CW-1:0] sx, sy, px, py;
    logic                 pix_on;
    logic [DW-1:0]        period_m1;

`ifdef FORMATION_SPEEDUP_EN
    logic [DW-1:0]        period, period_nxt;
    assign period_m1 = period - DW'(1);
`else
    assign period_m1 = DW'(MOVE_DIV - 1);
`endif

    assign sx = signed'(CW'(shot_x));
    assign sy = signed'(CW'(shot_y));
    assign px = signed'(CW'(h_counter));
    assign py = signed'(CW'(v_counter));

    // Which columns and rows still hold at least one living enemy.
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive[r*COLS + c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
            end
        end
    end

    // Formation extents over living columns/rows only.
    always_comb begin
        right_edge  = base_x;
        left_edge   = base_x;
        bottom_edge = base_y;
        for (int c = 0; c < COLS; c++)
            if (col_alive[c]) right_edge = base_x + CW'(c*DX + SPR_W - 1);
        for (int c = COLS - 1; c >= 0; c--)
            if (col_alive[c]) left_edge = base_x + CW'(c*DX);
        for (int r = 0; r < ROWS; r++)
            if (row_alive[r]) bottom_edge = base_y + CW'(r*DY + SPR_H - 1);
    end

    assign floor_hit = (row_alive != '0) && (bottom_edge >= CW'(Y_FLOOR));

    // Shot-vs-box test at current positions; scanned high to low so the
    // lowest qualifying index wins.
    always_comb begin : hit_detect
        logic signed [CW-1:0] ex, ey;
        shot_hit = 1'b0;
        shot_idx = '0;
        ex       = '0;
        ey       = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            for (int c = COLS - 1; c >= 0; c--) begin
                ex = base_x + CW'(c*DX);
                ey = base_y + CW'(r*DY);
                if (shot_valid && alive[r*COLS + c] &&
                    sx >= ex && sx <= ex + CW'(SPR_W - 1) &&
                    sy >= ey && sy <= ey + CW'(SPR_H - 1)) begin
                    shot_hit = 1'b1;
                    shot_idx = IDW'(r*COLS + c);
                end
            end
        end
    end

    // Next-state: restart, then kill, divider, march and halt conditions.
    always_comb begin
        state_nxt     = state;
        from_left_nxt = from_left;
        base_x_nxt    = base_x;
        base_y_nxt    = base_y;
        alive_nxt     = alive;
        tick_cnt_nxt  = tick_cnt;
        hit_nxt       = 1'b0;
        hit_id_nxt    = hit_id;
        cleared_nxt   = cleared;
        bottom_nxt    = reached_bottom;
        march_ev      = 1'b0;
`ifdef FORMATION_SPEEDUP_EN
        period_nxt    = period;
`endif
        if (restart) begin
            state_nxt     = MARCH_R;
            from_left_nxt = 1'b0;
            base_x_nxt    = CW'(X0);
            base_y_nxt    = CW'(Y0);
            alive_nxt     = '1;
            tick_cnt_nxt  = '0;
            cleared_nxt   = 1'b0;
            bottom_nxt    = 1'b0;
`ifdef FORMATION_SPEEDUP_EN
            period_nxt    = DW'(MOVE_DIV);
`endif
        end else begin
            if (shot_hit) begin
                alive_nxt[shot_idx] = 1'b0;
                hit_nxt             = 1'b1;
                hit_id_nxt          = shot_idx;
            end

            if (tick && state != HALT) begin
                if (tick_cnt == period_m1) begin
                    tick_cnt_nxt = '0;
                    march_ev     = 1'b1;
                end else begin
                    tick_cnt_nxt = tick_cnt + DW'(1);
                end
            end

            if (march_ev && !floor_hit) begin
`ifdef FORMATION_SPEEDUP_EN
                begin : speedup
                    int spd;
                    spd = (MOVE_DIV * int'(alive_count)) / int'(N);
                    if (spd < 1) spd = 1;
                    period_nxt = DW'(spd);
                end
`endif
                unique case (state)
                    MARCH_R: begin
                        if (right_edge + CW'(STEP) > CW'(X_MAX)) begin
                            state_nxt     = DESCEND;
                            from_left_nxt = 1'b0;
                        end else begin
                            base_x_nxt = base_x + CW'(STEP);
                        end
                    end
                    MARCH_L: begin
                        if (left_edge - CW'(STEP) < CW'(X_MIN)) begin
                            state_nxt     = DESCEND;
                            from_left_nxt = 1'b1;
                        end else begin
                            base_x_nxt = base_x - CW'(STEP);
                        end
                    end
                    DESCEND: begin
                        base_y_nxt = base_y + CW'(DROP);
                        state_nxt  = from_left ? MARCH_R : MARCH_L;
                    end
                    default: ;
                endcase
            end

            if (alive_nxt == '0) begin
                state_nxt   = HALT;
                cleared_nxt = 1'b1;
            end else if (floor_hit) begin
                state_nxt  = HALT;
                bottom_nxt = 1'b1;
            end
        end
        alive_count_nxt = CNTW'($countones(alive_nxt));
    end

    // Formation state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= MARCH_R;
            from_left      <= 1'b0;
            base_x         <= CW'(X0);
            base_y         <= CW'(Y0);
            alive          <= '1;
            tick_cnt       <= '0;
            hit            <= 1'b0;
            hit_id         <= '0;
            alive_count    <= CNTW'(N);
            cleared        <= 1'b0;
            reached_bottom <= 1'b0;
`ifdef FORMATION_SPEEDUP_EN
            period         <= DW'(MOVE_DIV);
`endif
        end else begin
            state          <= state_nxt;
            from_left      <= from_left_nxt;
            base_x         <= base_x_nxt;
            base_y         <= base_y_nxt;
            alive          <= alive_nxt;
            tick_cnt       <= tick_cnt_nxt;
            hit            <= hit_nxt;
            hit_id         <= hit_id_nxt;
            alive_count    <= alive_count_nxt;
            cleared        <= cleared_nxt;
            reached_bottom <= bottom_nxt;
`ifdef FORMATION_SPEEDUP_EN
            period         <= period_nxt;
`endif
        end
    end

    // Is the current pixel inside any living enemy box.
    always_comb begin : pixel_hit
        logic signed [CW-1:0] ex, ey;
        pix_on = 1'b0;
        ex     = '0;
        ey     = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ex = base_x + CW'(c*DX);
                ey = base_y + CW'(r*DY);
                if (alive[r*COLS + c] &&
                    px >= ex && px <= ex + CW'(SPR_W - 1) &&
                    py >= ey && py <= ey + CW'(SPR_H - 1))
                    pix_on = 1'b1;
            end
        end
    end

    // Registered pixel colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            R <= 8'h00;
            G <= 8'h00;
            B <= 8'h00;
        end else begin
            R <= pix_on ? ENEMY_R : 8'h00;
            G <= pix_on ? ENEMY_G : 8'h00;
            B <= pix_on ? ENEMY_B : 8'h00;
        end
    end

endmodule

// File: tb/tb_enemy_formation.sv
// Directed bench for enemy_formation. "dut" uses the default geometry;
// "dut2" is a narrower (6 columns), vertically overlapping (DY=20) build
// that fits the field so its first march event is a real step.
module tb_enemy_formation;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        restart;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic        shot_valid;
    logic [10:0] shot_x;
    logic [10:0] shot_y;

    logic        hit, cleared, reached_bottom;
    logic [4:0]  hit_id;
    logic [5:0]  alive_count;
    logic [7:0]  R, G, B;

    logic        hit2, cleared2, reached_bottom2;
    logic [4:0]  hit_id2;
    logic [5:0]  alive_count2;
    logic [7:0]  R2, G2, B2;

    int n_cmp = 0;
    int n_bad = 0;
    int hit_pulses = 0;
    int hit2_pulses = 0;

    enemy_formation dut (
        .clk(clk), .reset(reset), .tick(tick), .restart(restart),
        .h_counter(h_counter), .v_counter(v_counter),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .hit(hit), .hit_id(hit_id), .alive_count(alive_count),
        .cleared(cleared), .reached_bottom(reached_bottom),
        .R(R), .G(G), .B(B)
    );

    enemy_formation #(.COLS(6), .DY(20)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .restart(restart),
        .h_counter(h_counter), .v_counter(v_counter),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .hit(hit2), .hit_id(hit_id2), .alive_count(alive_count2),
        .cleared(cleared2), .reached_bottom(reached_bottom2),
        .R(R2), .G(G2), .B(B2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hit === 1'b1)  hit_pulses++;
        if (hit2 === 1'b1) hit2_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse_tick();
    endtask

    task automatic shoot(input int x, input int y);
        shot_x     = 11'(x);
        shot_y     = 11'(y);
        shot_valid = 1'b1;
        step();
        shot_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Pixel colour of both builds for point (x,y), one cycle later.
    task automatic probe(input int x, input int y, output logic [23:0] p1, output logic [23:0] p2);
        h_counter = 10'(x);
        v_counter = 10'(y);
        step();
        p1 = {R, G, B};
        p2 = {R2, G2, B2};
    endtask

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    initial begin
        logic [23:0] p1, p2;
        int h0, n_ticks;
        reset = 1'b0; tick = 1'b0; restart = 1'b0; shot_valid = 1'b0;
        shot_x = '0; shot_y = '0; h_counter = '0; v_counter = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit", hit, 0);
        check("rst_hit_id", hit_id, 0);
        check("rst_alive", alive_count, 24);
        check("rst_alive2", alive_count2, 18);
        check("rst_cleared", cleared, 0);
        check("rst_bottom", reached_bottom, 0);
        check("rst_rgb", {R, G, B}, 0);

        // 30 ticks after release: first march step on the fitting build.
        reset = 1'b1;
        step();
        h0 = hit_pulses + hit2_pulses;
        ticks(29);
        check("pre_march_x2", dut2.base_x, 180);
        ticks(1);
        check("march_x2", dut2.base_x, 188);
        check("march_state2", dut2.state, 0);
        check("no_hit_during_ticks", hit_pulses + hit2_pulses, h0);
        probe(188, 40, p1, p2);
        check("pix_left_in2", p2, WHITE);
        probe(187, 40, p1, p2);
        check("pix_left_out2", p2, BLACK);
        // Full 8-column formation overhangs X_MAX, so its first event descends.
        check("wide_descend", dut.state, 2);

        // Single kill, hit pulse and hit_id hold.
        do_restart();
        check("restart_alive", alive_count, 24);
        shoot(185, 45);
        check("hit0_pulse", hit, 1);
        check("hit0_id", hit_id, 0);
        check("hit0_alive", alive_count, 23);
        step();
        check("hit0_clear", hit, 0);
        probe(190, 50, p1, p2);
        check("pix_dead0", p1, BLACK);
        probe(270, 50, p1, p2);
        check("pix_alive1", p1, WHITE);
        shoot(590, 100);
        check("hit13_id", hit_id, 13);
        check("hit13_alive", alive_count, 22);
        step();
        check("hit13_clear", hit, 0);
        check("hit13_hold", hit_id, 13);

        // Restart wins over a simultaneous hit.
        shot_x = 11'd270; shot_y = 11'd50; shot_valid = 1'b1; restart = 1'b1;
        step();
        shot_valid = 1'b0; restart = 1'b0;
        check("restart_prio_hit", hit, 0);
        check("restart_prio_alive", alive_count, 24);

        // Dead outer columns 6,7 do not limit travel.
        for (int r = 0; r < 3; r++)
            for (int c = 6; c < 8; c++)
                shoot(190 + 80*c, 50 + 50*r);
        check("trim_alive", alive_count, 18);
        ticks(90);
        probe(204, 40, p1, p2);
        check("trim_x204_in", p1, WHITE);
        probe(203, 40, p1, p2);
        check("trim_x204_out", p1, BLACK);
        check("trim_state_r", dut.state, 0);
        ticks(30);
        check("trim_descend", dut.state, 2);
        check("trim_descend_x", dut.base_x, 204);
        ticks(30);
        check("trim_march_l", dut.state, 1);
        probe(204, 56, p1, p2);
        check("trim_y56_in", p1, WHITE);
        probe(204, 55, p1, p2);
        check("trim_y56_out", p1, BLACK);
        ticks(30);
        check("trim_step_left", dut.base_x, 196);

        // Reset in the middle of a descent discards it.
        do_restart();
        ticks(59);
        check("mid_descend", dut.state, 2);
        reset = 1'b0;
        #2;
        check("async_state", dut.state, 0);
        check("async_base_y", dut.base_y, 40);
        reset = 1'b1;
        step();
        ticks(30);
        check("post_rst_state", dut.state, 2);
        check("post_rst_y", dut.base_y, 40);

        // Clear all enemies, formation freezes, restart reloads.
        do_restart();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 8; c++) begin
                shoot(190 + 80*c, 50 + 50*r);
                check($sformatf("kill_id_%0d", r*8 + c), hit_id, r*8 + c);
            end
        end
        check("clr_alive", alive_count, 0);
        check("clr_cleared", cleared, 1);
        check("clr_state", dut.state, 3);
        ticks(100);
        check("clr_frozen_x", dut.base_x, 180);
        check("clr_frozen_y", dut.base_y, 40);
        check("clr_still", cleared, 1);
        do_restart();
        check("reload_alive", alive_count, 24);
        check("reload_cleared", cleared, 0);
        probe(180, 40, p1, p2);
        check("reload_origin_in", p1, WHITE);
        probe(179, 40, p1, p2);
        check("reload_origin_out", p1, BLACK);

        // March full sweeps until the bottom row touches the floor.
        n_ticks = 0;
        while (n_ticks < 4500 && reached_bottom !== 1'b1) begin
            pulse_tick();
            n_ticks++;
        end
        check("bottom_flag", reached_bottom, 1);
        check("bottom_ticks", n_ticks, 4140);
        check("bottom_state", dut.state, 3);
        probe(4, 428, p1, p2);
        check("bottom_in", p1, WHITE);
        probe(3, 428, p1, p2);
        check("bottom_out_x", p1, BLACK);
        ticks(60);
        check("bottom_frozen_y", dut.base_y, 328);
        probe(4, 428, p1, p2);
        check("bottom_frozen_pix", p1, WHITE);
        shoot(10, 433);
        check("halt_hit", hit, 1);
        check("halt_hit_id", hit_id, 16);
        check("halt_alive", alive_count, 23);

        // Overlapping boxes, shot coincident with a march event.
        do_restart();
        ticks(29);
        tick = 1'b1; shot_valid = 1'b1; shot_x = 11'd185; shot_y = 11'd61;
        step();
        tick = 1'b0; shot_valid = 1'b0;
        check("ovl_hit", hit2, 1);
        check("ovl_id", hit_id2, 0);
        check("ovl_alive", alive_count2, 17);
        check("ovl_moved", dut2.base_x, 188);
        probe(190, 61, p1, p2);
        check("ovl_survivor", p2, WHITE);
        probe(190, 45, p1, p2);
        check("ovl_killed", p2, BLACK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
